// File: rtl/results_conv_pkg.sv
// Shared types and constants for the results digit link receiver.
// Also holds the saturating counter helper used by the link health counters.
package results_conv_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam int BYTE_W = 8;
  localparam int CNT_W  = 8;

  localparam logic [3:0] HDR_TAG_DEF = 4'hA;

  typedef enum logic [1:0] {
    IDLE,
    HI,
    LO,
    COMMIT
  } rx_state_e;

  function automatic logic [CNT_W-1:0] sat_add(
    input logic [CNT_W-1:0] c,
    input logic [1:0]       n
  );
    logic [CNT_W:0] s;
    s = {1'b0, c} + (CNT_W+1)'(n);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/digit_clk_sync.sv
// Synchronizes the transmitter byte strobe into clk.
// Emits a one-cycle byte_stb on each digit_clk rising edge.
module digit_clk_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic digit_clk,
  output logic byte_stb
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;
  logic                   prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], digit_clk};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign byte_stb = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/results_digit_rx.sv
// Reassembles 3-byte digit link frames into 16-bit words.
// Writes each word into a 16-entry result table with link health counters.
module results_digit_rx
  import results_conv_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter int         TIMEOUT     = 1024,
  parameter logic [3:0] HDR_TAG     = HDR_TAG_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] dout,
  input  logic              dout_flag,
  input  logic              digit_clk,
  input  logic              test_mode,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [15:0]       valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic byte_stb;
  logic hdr_ok;

  rx_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic [CNT_W-1:0]  frm_q, frm_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [DATA_W-1:0] tbl_q [16];
  logic [DATA_W-1:0] tbl_d [16];
  logic [15:0]       valid_q, valid_d;

  digit_clk_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .digit_clk(digit_clk),
    .byte_stb (byte_stb)
  );

  assign hdr_ok = (dout[7:4] == HDR_TAG);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    frm_d     = frm_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    tbl_d     = tbl_q;
    valid_d   = valid_q;
    unique case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (byte_stb && dout_flag) begin
          if (hdr_ok) begin
            addr_d  = dout[3:0];
            state_d = HI;
          end else begin
            err_d = sat_add(err_q, 2'd1);
          end
        end
      end
      HI, LO: begin
        if (byte_stb) begin
          tmo_d = '0;
          if (dout_flag) begin
            // Header inside a frame restarts framing on the new header
            if (hdr_ok) begin
              err_d   = sat_add(err_q, 2'd1);
              addr_d  = dout[3:0];
              state_d = HI;
            end else begin
              err_d   = sat_add(err_q, 2'd2);
              state_d = IDLE;
            end
          end else if (state_q == HI) begin
            data_d[15:8] = dout;
            state_d      = LO;
          end else begin
            data_d[7:0] = dout;
            state_d     = COMMIT;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          err_d   = sat_add(err_q, 2'd1);
          tmo_d   = '0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      COMMIT: begin
        wr_en_d   = 1'b1;
        wr_addr_d = addr_q;
        wr_data_d = data_q;
        frm_d     = sat_add(frm_q, 2'd1);
        if (!test_mode) begin
          tbl_d[addr_q]   = data_q;
          valid_d[addr_q] = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      tmo_q     <= '0;
      err_q     <= '0;
      frm_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      valid_q   <= '0;
      for (int i = 0; i < 16; i++) tbl_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      frm_q     <= frm_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      valid_q   <= valid_d;
      for (int i = 0; i < 16; i++) tbl_q[i] <= tbl_d[i];
    end
  end

  assign rd_data   = tbl_q[rd_addr];
  assign valid     = valid_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign frame_cnt = frm_q;
  assign err_cnt   = err_q;

endmodule
